// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/ready input; define UART_TX_PARITY_EN to insert an even parity bit (8E1)
module uart_tx #(
  parameter int CLK_FREQUENCY  = 66_000_000,
  parameter int UART_FREQUENCY = 921_600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy
);
  localparam int TICKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY;
  localparam logic [14:0] LAST_TICK = 15'(TICKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [14:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tx_d, wrap, done, accept;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign wrap   = tick_q == LAST_TICK;
  assign done   = bit_q == 3'd7;
  assign ready  = state_q == IDLE && !rst;
  assign busy   = !ready;
  assign accept = valid && ready;
  // next-state, counters, shift register and the line level for the current state
  always_comb begin
    state_d = state_q;
    tick_d  = wrap ? '0 : tick_q + 15'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (accept) begin
          state_d = START;
          sh_d    = data;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      START: begin
        tx_d    = 1'b0;
        state_d = wrap ? DATA : START;
      end
      DATA: begin
        tx_d = sh_q[0];
        if (wrap) begin
          sh_d    = sh_q >> 1;
          bit_d   = done ? bit_q : bit_q + 3'd1;
          state_d = done ? AFTER_DATA : DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d    = par_q;
        state_d = wrap ? STOP : PARITY;
      end
`endif
      STOP: state_d = wrap ? IDLE : STOP;
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end
  // state and datapath registers; tx lags the state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at T=8 cycles per bit
module tb_uart_tx;
  localparam int T = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst, valid, ready, tx, busy;
  logic [7:0] data;
  int n_chk = 0, n_pass = 0, cyc = 0, n_push = 0, n_frames = 0;
  int cur_start = 0, prev_start = 0, last_start = 0;
  logic [7:0] exp_q[$];
  logic [NB-1:0] m_bits;
  logic m_gl, m_ab;
  logic [7:0] m_e;
  int m_st;

  uart_tx #(.CLK_FREQUENCY(8_000_000), .UART_FREQUENCY(1_000_000)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data),
    .ready(ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    wait_ready();
    exp_q.push_back(b);
    n_push++;
    @(negedge clk);
    valid = 1'b0;
    data  = 8'($urandom);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !rst) begin
        m_st = cyc;
        cur_start = cyc;
        m_gl = 1'b0;
        m_ab = 1'b0;
        m_bits = '0;
        for (int k = 0; k < NB && !m_ab; k++)
          for (int j = 0; j < T && !m_ab; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (rst) m_ab = 1'b1;
            else if (j == 0) m_bits[k] = tx;
            else if (tx !== m_bits[k]) m_gl = 1'b1;
          end
        if (m_ab) begin
          while (rst) @(negedge clk);
        end else begin
          n_frames++;
          prev_start = last_start;
          last_start = m_st;
          chk("bit_hold", m_gl, 0);
          chk("start_bit", m_bits[0], 0);
          chk("stop_bit", m_bits[NB-1], 1);
          if (exp_q.size() == 0) chk("extra_frame", 1, 0);
          else begin
            m_e = exp_q.pop_front();
            chk("data", m_bits[8:1], m_e);
`ifdef UART_TX_PARITY_EN
            chk("parity", m_bits[9], ^m_e);
`endif
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    valid = 1'b1;
    data = 8'h3C;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_tx", tx, 1);
    end
    rst = 1'b0;
    valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", ready, 1);
      chk("idle_busy", busy, 0);
    end
    send(8'hA5);
    chk("busy_after_accept", busy, 1);
    wait_ready();
    chk("ready_lat", cyc - cur_start + 1, NB * T);
`ifdef UART_TX_PARITY_EN
    send(8'h07);
    wait_ready();
`endif
    @(negedge clk);
    valid = 1'b1;
    data = 8'h00;
    wait_ready();
    exp_q.push_back(8'h00);
    n_push++;
    @(negedge clk);
    data = 8'hFF;
    wait_ready();
    exp_q.push_back(8'hFF);
    n_push++;
    @(negedge clk);
    valid = 1'b0;
    wait_ready();
    repeat (4) @(negedge clk);
    chk("b2b_gap", last_start - prev_start, NB * T + 1);
    send(8'h11);
    repeat (18) @(negedge clk);
    valid = 1'b1;
    data = 8'h3C;
    repeat (4) begin
      @(negedge clk);
      chk("ignored_ready", ready, 0);
    end
    valid = 1'b0;
    wait_ready();
    repeat (4) @(negedge clk);
    send(8'h55);
    repeat (34) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_ready", ready, 0);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    n_push--;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tx", tx, 1);
    send(8'h81);
    wait_ready();
    repeat (NB * T + 10) @(negedge clk);
    chk("frames", n_frames, n_push);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
